// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV64 fetch constants and the fetch queue entry type.
package riscv_pkg;
  localparam int XLEN = 64;
  localparam int INSTR_W = 32;
  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic               misaligned;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue_mem.sv
// fetch_queue_mem: DEPTH x entry register array, one write port, asynchronous read.
module fetch_queue_mem
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         we,
  input  logic [AW-1:0] waddr,
  input  fetch_entry_t wdata,
  input  logic [AW-1:0] raddr,
  output fetch_entry_t rdata
);
  fetch_entry_t mem_q [DEPTH];
  always_ff @(posedge clk)
    if (we) mem_q[waddr] <= wdata;
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: decoupling FIFO between fetch and decode with PC backpressure and flush.
// Define FETCH_QUEUE_BYPASS_EN to let an empty queue pass the input straight to decode.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ADDR_W = XLEN,
  parameter int INSTR_W = riscv_pkg::INSTR_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [ADDR_W-1:0]        in_pc,
  input  logic [INSTR_W-1:0]       in_instr,
  output logic                     in_ready,
  output logic                     pc_stall,
  output logic                     out_valid,
  output logic [ADDR_W-1:0]        out_pc,
  output logic [INSTR_W-1:0]       out_instr,
  output logic                     out_misaligned,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW:0]   count_q, count_d;
  fetch_entry_t  wr_entry, rd_entry, head;
  logic          push, pop, byp, empty;
  assign empty    = count_q == '0;
  assign in_ready = count_q != (PW+1)'(DEPTH);
  assign pc_stall = ~in_ready;
  assign count    = count_q;
  assign wr_entry = '{pc: XLEN'(in_pc), instr: riscv_pkg::INSTR_W'(in_instr), misaligned: |in_pc[1:0]};
`ifdef FETCH_QUEUE_BYPASS_EN
  assign byp = empty && in_valid && !flush;
`else
  assign byp = 1'b0;
`endif
  // a bypassed pair that decode takes immediately is never written
  assign push      = in_valid && in_ready && !flush && !(byp && out_ready);
  assign pop       = !empty && out_ready && !flush;
  assign out_valid = !empty || byp;
  assign head      = byp ? wr_entry : (empty ? '0 : rd_entry);
  assign out_pc         = ADDR_W'(head.pc);
  assign out_instr      = INSTR_W'(head.instr);
  assign out_misaligned = head.misaligned;
  always_comb begin
    wptr_d  = wptr_q + PW'(push);
    rptr_d  = rptr_q + PW'(pop);
    count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
  end
  always_ff @(posedge clk)
    if (!rst_n || flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  fetch_queue_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wptr_q),
    .wdata (wr_entry),
    .raddr (rptr_q),
    .rdata (rd_entry)
  );
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and random stimulus checked against a queue-based reference model.
module tb_fetch_queue;
  localparam int DEPTH = 4;
  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [63:0] in_pc;
  logic [31:0] in_instr;
  logic        in_ready, pc_stall, out_valid, out_misaligned;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  count;
  int tests = 0, fails = 0;
  typedef struct {logic [63:0] pc; logic [31:0] instr;} ent_t;
  ent_t q[$];

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_pc(in_pc),
    .in_instr(in_instr), .in_ready(in_ready), .pc_stall(pc_stall), .out_valid(out_valid),
    .out_pc(out_pc), .out_instr(out_instr), .out_misaligned(out_misaligned),
    .out_ready(out_ready), .count(count)
  );

  always @(negedge clk)
    if (rst_n === 1'b1)
      assert (count <= DEPTH) else begin
        fails++;
        $error("FAIL count_bound observed=%0d expected<=%0d", count, DEPTH);
      end

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, o, e);
    end
  endtask

  task automatic cyc(input logic v, input logic [63:0] pc, input logic rdy, input logic fl, input logic rn);
    logic [31:0] ins;
    logic byp, push, pop;
    ent_t h;
    @(negedge clk);
    ins = $urandom;
    in_valid = v; in_pc = pc; in_instr = ins; out_ready = rdy; flush = fl; rst_n = rn;
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    byp = q.size() == 0 && v && !fl;
`else
    byp = 1'b0;
`endif
    h = byp ? '{pc, ins} : (q.size() > 0 ? q[0] : '{64'd0, 32'd0});
    chk("count", 64'(count), 64'(q.size()));
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0 || byp));
    chk("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
    chk("pc_stall", 64'(pc_stall), 64'(q.size() >= DEPTH));
    chk("out_pc", out_pc, h.pc);
    chk("out_instr", 64'(out_instr), 64'(h.instr));
    chk("out_misaligned", 64'(out_misaligned), 64'(h.pc[1:0] != 2'b00));
    push = v && q.size() < DEPTH && !fl && !(byp && rdy);
    pop = q.size() > 0 && rdy && !fl;
    @(posedge clk);
    if (!rn || fl) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back('{pc, ins});
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_pc = '0; in_instr = '0;
    repeat (2) @(posedge clk);
    q.delete();
    // reset then stream
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 64'(4 * i), 1'b1, 1'b0, 1'b1);
      #1 chk("stream_count", 64'(count), 64'd1);
      chk("stream_pc", out_pc, 64'(4 * i));
    end
    cyc(1'b0, 64'd0, 1'b1, 1'b0, 1'b1);
    // fill and stall
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 64'(4 * i), 1'b0, 1'b0, 1'b1);
      if (i == 3) begin
        #1 chk("full_count", 64'(count), 64'd4);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_pc_stall", 64'(pc_stall), 64'd1);
      end
    end
    for (int i = 0; i < 4; i++) begin
      #1 chk("drain_pc", out_pc, 64'(4 * i));
      cyc(1'b0, 64'd0, 1'b1, 1'b0, 1'b1);
    end
    // simultaneous push/pop at count 2, wrapping the pointers
    cyc(1'b1, 64'h20, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 64'h24, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 64'(64'h28 + 4 * i), 1'b1, 1'b0, 1'b1);
      #1 chk("pp_count", 64'(count), 64'd2);
    end
    // flush at count 3
    cyc(1'b1, 64'h80, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 64'h100, 1'b0, 1'b1, 1'b1);
    #1 chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    cyc(1'b1, 64'h200, 1'b0, 1'b0, 1'b1);
    #1 chk("post_flush_pc", out_pc, 64'h200);
    chk("post_flush_count", 64'(count), 64'd1);
    cyc(1'b0, 64'd0, 1'b1, 1'b0, 1'b1);
    // misaligned entry and mid-run reset
    cyc(1'b1, 64'h6, 1'b0, 1'b0, 1'b1);
    #1 chk("misaligned", 64'(out_misaligned), 64'd1);
    cyc(1'b1, 64'h8, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 64'hc, 1'b0, 1'b0, 1'b0);
    #1 chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
`ifdef FETCH_QUEUE_BYPASS_EN
    cyc(1'b1, 64'h40, 1'b1, 1'b0, 1'b1);
    #1 chk("bypass_count", 64'(count), 64'd0);
`endif
    // randomized traffic with occasional flush and reset
    for (int i = 0; i < 300; i++)
      cyc(1'($urandom_range(0, 3) != 0), {$urandom, $urandom}, 1'($urandom_range(0, 2) == 0),
          1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 40) != 0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
